// File: rtl/mem_stage.sv
// RV32I memory-access stage: turns loads/stores into a request/ready bus access,
// stalls upstream while busy, formats load data. Optional: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_read_data_out,
    output logic [4:0]  rd_out,
    output logic        stall_out,
    output logic        bus_err_out,
    output logic        misalign_out
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] rbuf;
    logic        err;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        mem_op;
    logic        store_bad;
    logic        mis;
    logic        start;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx;
    logic [31:0] fmt_data;
    logic        load_ok;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign mem_op    = valid_in & (MemRead_in | MemWrite_in);
    assign store_bad = MemWrite_in & ~(funct3_in == 3'b000 || funct3_in == 3'b001 ||
                                       funct3_in == 3'b010);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = mem_op & ~store_bad &
                 ((((funct3_in == 3'b001) || (funct3_in == 3'b101)) && alu_result_in[0]) ||
                  ((funct3_in == 3'b010) && (alu_result_in[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    assign start = (state == IDLE) & mem_op & ~store_bad & ~mis;

    always_comb begin
        be_nx    = 4'b1111;
        wdata_nx = store_data_in;
        if (MemWrite_in) begin
            case (funct3_in)
                3'b000: begin
                    be_nx    = 4'b0001 << alu_result_in[1:0];
                    wdata_nx = {4{store_data_in[7:0]}};
                end
                3'b001: begin
                    be_nx    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                    wdata_nx = {2{store_data_in[15:0]}};
                end
                default: begin
                    be_nx    = 4'b1111;
                    wdata_nx = store_data_in;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            rbuf    <= 32'd0;
            err     <= 1'b0;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= {alu_result_in[31:2], 2'b00};
                        lane_q  <= alu_result_in[1:0];
                        f3_q    <= funct3_in;
                        we_q    <= MemWrite_in;
                        be_q    <= be_nx;
                        wdata_q <= wdata_nx;
                        cnt     <= 8'd0;
                        err     <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        rbuf  <= dmem_rdata;
                        cnt   <= 8'd0;
                        req_q <= 1'b0;
                        state <= DONE;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        // abandon the access; the bus must tolerate a dropped request
                        err   <= 1'b1;
                        cnt   <= 8'd0;
                        req_q <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        byte_sel = rbuf[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? rbuf[31:16] : rbuf[15:0];
        load_ok  = 1'b1;
        case (f3_q)
            3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  fmt_data = {24'd0, byte_sel};
            3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  fmt_data = {16'd0, half_sel};
            3'b010:  fmt_data = rbuf;
            default: begin
                fmt_data = 32'd0;
                load_ok  = 1'b0;
            end
        endcase
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    // writeback fields are combinational; held at zero while reset is asserted
    always_comb begin
        RegWrite_out      = 1'b0;
        MemToReg_out      = 1'b0;
        alu_result_out    = 32'd0;
        mem_read_data_out = 32'd0;
        rd_out            = 5'd0;
        stall_out         = 1'b0;
        bus_err_out       = 1'b0;
        misalign_out      = 1'b0;
        if (!rst) begin
            MemToReg_out   = MemToReg_in;
            alu_result_out = alu_result_in;
            rd_out         = rd_in;
            case (state)
                IDLE: begin
                    if (start) begin
                        stall_out = 1'b1;
                    end else if (mem_op) begin
                        misalign_out = mis;
                    end else begin
                        RegWrite_out = valid_in & RegWrite_in;
                    end
                end
                REQ: stall_out = 1'b1;
                DONE: begin
                    mem_read_data_out = we_q ? 32'd0 : fmt_data;
                    RegWrite_out      = valid_in & RegWrite_in & ~err & (we_q | load_ok);
                    bus_err_out       = err;
                end
                default: stall_out = 1'b0;
            endcase
        end
    end

endmodule
